// File: rtl/shift_unit.sv
// Multi-cycle barrel-lite shifter for the MIPS datapath: SLL, SRL, SRA and LUI,
// moving at most STEP bit positions per clock behind a start/busy/done handshake.
module shift_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned STEP    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int unsigned CNT_W = SHAMT_W + 1;
    localparam int unsigned HALF  = WIDTH / 2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_LUI = 2'b11;

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [1:0]         op_q;
    logic               sign_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;

    logic [CNT_W-1:0]   cnt_ext;
    logic [CNT_W-1:0]   step_amt;
    logic               last_step;
    logic [WIDTH-1:0]   fill_mask;
    logic [WIDTH-1:0]   work_d;
    logic [SHAMT_W-1:0] cnt_d;
    logic [SHAMT_W-1:0] cap_cnt;

    // One RUN step: shift by min(cnt, STEP); SRA fills the vacated top bits with the captured sign.
    always_comb begin
        cnt_ext   = CNT_W'(cnt_q);
        last_step = (cnt_ext <= STEP_C);
        step_amt  = last_step ? cnt_ext : STEP_C;
        fill_mask = ~({WIDTH{1'b1}} >> step_amt);
        work_d    = work_q;
        case (op_q)
            OP_SLL, OP_LUI: work_d = work_q << step_amt;
            OP_SRL:         work_d = work_q >> step_amt;
            OP_SRA:         work_d = (work_q >> step_amt) | (sign_q ? fill_mask : '0);
            default:        work_d = work_q;
        endcase
        cnt_d = SHAMT_W'(cnt_ext - step_amt);
    end

    // Amount captured on acceptance; LUI ignores shamt and always moves by half the width.
    always_comb begin
        cap_cnt = shamt;
        if (op == OP_LUI) begin
            cap_cnt = SHAMT_W'(HALF);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (start) begin
                        work_q <= a;
                        op_q   <= op;
                        sign_q <= a[WIDTH-1];
                        cnt_q  <= cap_cnt;
                        if (cap_cnt == '0) begin
                            result_q <= a;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_d;
                    if (last_step) begin
                        result_q <= work_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (WIDTH=32, STEP=4): latency, handshake, result
// holding, back-to-back issue, ignored start during RUN and mid-RUN reset.
module tb_shift_unit;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] LUI = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [4:0] sh);
        start = 1'b1;
        op    = o;
        a     = av;
        shamt = sh;
        step();
        start = 1'b0;
        a     = 32'h5A5A_5A5A;
        shamt = 5'd17;
    endtask

    // Called just after the accepting edge: k busy cycles holding the old result, then a done pulse.
    task automatic run_check(input string tag, input int k, input logic [31:0] prev,
                             input logic [31:0] exp);
        for (int i = 0; i < k; i++) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " no-done"}, 32'(done), 32'd0);
            chk({tag, " hold"}, result, prev);
            step();
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " idle-busy"}, 32'(busy), 32'd0);
        chk({tag, " result"}, result, exp);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = SLL;
        a     = '0;
        shamt = '0;
        step();
        step();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", result, 32'h0);
        reset = 1'b0;
        step();

        // SLL 1 by 31: eight shift edges
        issue(SLL, 32'h0000_0001, 5'd31);
        run_check("s1 sll31", 8, 32'h0, 32'h8000_0000);
        step();
        chk("s1 done-pulse", 32'(done), 32'd0);

        // SRA / SRL by 4: single shift edge
        issue(SRA, 32'h8000_00F0, 5'd4);
        run_check("s2 sra4", 1, 32'h8000_0000, 32'hF800_000F);
        step();
        issue(SRL, 32'h8000_00F0, 5'd4);
        run_check("s2 srl4", 1, 32'hF800_000F, 32'h0800_000F);
        step();

        // LUI ignores shamt, moves 16 positions
        issue(LUI, 32'h1234_ABCD, 5'd7);
        run_check("s3 lui", 4, 32'h0800_000F, 32'hABCD_0000);
        step();

        // Zero shift completes on the accepting edge; start held for back-to-back issue
        start = 1'b1;
        op    = SRL;
        a     = 32'hDEAD_BEEF;
        shamt = 5'd0;
        step();
        chk("s4 zero done", 32'(done), 32'd1);
        chk("s4 zero busy", 32'(busy), 32'd0);
        chk("s4 zero result", result, 32'hDEAD_BEEF);
        op    = SLL;
        shamt = 5'd8;
        step();
        start = 1'b0;
        run_check("s4 b2b sll8", 2, 32'hDEAD_BEEF, 32'hADBE_EF00);
        step();

        // Start pulsed during RUN is ignored
        issue(SLL, 32'h0000_0001, 5'd20);
        chk("s5 busy e0", 32'(busy), 32'd1);
        step();
        start = 1'b1;
        a     = 32'hFFFF_FFFF;
        shamt = 5'd3;
        step();
        start = 1'b0;
        chk("s5 busy e2", 32'(busy), 32'd1);
        chk("s5 hold e2", result, 32'hADBE_EF00);
        step();
        step();
        chk("s5 busy e4", 32'(busy), 32'd1);
        chk("s5 no-done e4", 32'(done), 32'd0);
        step();
        chk("s5 done", 32'(done), 32'd1);
        chk("s5 result", result, 32'h0010_0000);
        step();
        chk("s5 after done", 32'(done), 32'd0);
        chk("s5 after busy", 32'(busy), 32'd0);
        chk("s5 idle hold", result, 32'h0010_0000);

        // Reset mid-RUN aborts without a done pulse
        issue(SRA, 32'h8000_0000, 5'd31);
        step();
        step();
        reset = 1'b1;
        step();
        chk("s6 rst busy", 32'(busy), 32'd0);
        chk("s6 rst done", 32'(done), 32'd0);
        chk("s6 rst result", result, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("s6 no done", 32'(done), 32'd0);
        end
        issue(SLL, 32'h0000_0001, 5'd31);
        run_check("s6 rerun", 8, 32'h0, 32'h8000_0000);
        step();

        // SRA by 31 replicates the sign bit
        issue(SRA, 32'h8000_0000, 5'd31);
        run_check("sra31", 8, 32'h8000_0000, 32'hFFFF_FFFF);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
